// File: rtl/adsr_pkg.sv
// Shared ADSR definitions: phase encodings, gain range and config addresses.
// Used by the envelope sequencer and the ADSR gain datapath.
package adsr_pkg;

    typedef enum logic [2:0] {
        PH_IDLE    = 3'd0,
        PH_ATTACK  = 3'd1,
        PH_DECAY   = 3'd2,
        PH_SUSTAIN = 3'd3,
        PH_RELEASE = 3'd4
    } phase_e;

    localparam logic [3:0] MAX_GAIN_IDX = 4'd9;

    localparam logic [1:0] CFG_ATTACK  = 2'd0;
    localparam logic [1:0] CFG_DECAY   = 2'd1;
    localparam logic [1:0] CFG_RELEASE = 2'd2;
    localparam logic [1:0] CFG_SUSTAIN = 2'd3;

    function automatic logic [3:0] clamp_gain(input logic [3:0] v);
        return (v > MAX_GAIN_IDX) ? MAX_GAIN_IDX : v;
    endfunction

endpackage

// File: rtl/dffre.sv
// Enabled register with synchronous active-low reset.
module dffre #(
    parameter int           W   = 1,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RST;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/step_timer.sv
// Sample-tick counter; flags a step boundary on the tick that reaches len-1.
module step_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        clear,
    input  logic [15:0] len,
    output logic        boundary
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [15:0] last;

    // A zero length behaves as one tick per step.
    assign last = (len == 16'd0) ? 16'd0 : len - 16'd1;

    // >= keeps a shortened length from letting the counter run past it.
    assign boundary = tick && !clear && (cnt_q >= last);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || boundary) begin
            cnt_d = 16'd0;
        end else if (tick) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    dffre #(.W(16)) u_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (1'b1),
        .d     (cnt_d),
        .q     (cnt_q)
    );

endmodule

// File: rtl/env_sequencer.sv
// ADSR envelope phase sequencer: steps a gain index through
// attack/decay/sustain/release on codec sample ticks.
module env_sequencer
    import adsr_pkg::*;
#(
    parameter int DEF_STEP_LEN = 480,
    parameter int DEF_SUSTAIN  = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_tick,
    input  logic        note_on,
    input  logic        note_off,
    input  logic        cfg_wr,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    output logic [2:0]  phase,
    output logic [3:0]  gain_idx,
    output logic        step_tick,
    output logic        busy,
    output logic        done
);

    localparam logic [15:0] LEN_RST = 16'(DEF_STEP_LEN);
    localparam logic [3:0]  SUS_RST = clamp_gain(4'(DEF_SUSTAIN));

    logic [15:0] len_a_q, len_d_q, len_r_q, cur_len;
    logic [3:0]  sus_q, sus_d;
    logic [2:0]  ph_raw;
    phase_e      ph_q, ph_d;
    logic [3:0]  gain_q, gain_d, gain_inc, gain_dec;
    logic        step_q, step_d, done_q, done_d;
    logic        evt_on, evt_off, clr, bnd;

    dffre #(.W(16), .RST(LEN_RST)) u_len_a (
        .clk(clk), .rst_n(reset),
        .en(cfg_wr && cfg_addr == CFG_ATTACK),
        .d(cfg_data), .q(len_a_q)
    );

    dffre #(.W(16), .RST(LEN_RST)) u_len_d (
        .clk(clk), .rst_n(reset),
        .en(cfg_wr && cfg_addr == CFG_DECAY),
        .d(cfg_data), .q(len_d_q)
    );

    dffre #(.W(16), .RST(LEN_RST)) u_len_r (
        .clk(clk), .rst_n(reset),
        .en(cfg_wr && cfg_addr == CFG_RELEASE),
        .d(cfg_data), .q(len_r_q)
    );

    assign sus_d = clamp_gain(cfg_data[3:0]);

    dffre #(.W(4), .RST(SUS_RST)) u_sus (
        .clk(clk), .rst_n(reset),
        .en(cfg_wr && cfg_addr == CFG_SUSTAIN),
        .d(sus_d), .q(sus_q)
    );

    // note_on beats note_off; note_off only matters while the key is held.
    assign evt_on  = note_on;
    assign evt_off = note_off && !note_on &&
                     (ph_q == PH_ATTACK || ph_q == PH_DECAY ||
                      ph_q == PH_SUSTAIN);
    assign clr     = evt_on || evt_off ||
                     ph_q == PH_IDLE || ph_q == PH_SUSTAIN;

    always_comb begin
        cur_len = len_a_q;
        unique case (ph_q)
            PH_DECAY:   cur_len = len_d_q;
            PH_RELEASE: cur_len = len_r_q;
            default:    cur_len = len_a_q;
        endcase
    end

    step_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .tick     (sample_tick),
        .clear    (clr),
        .len      (cur_len),
        .boundary (bnd)
    );

    assign gain_inc = (gain_q >= MAX_GAIN_IDX) ? MAX_GAIN_IDX
                                                : gain_q + 4'd1;
    assign gain_dec = (gain_q == 4'd0) ? 4'd0 : gain_q - 4'd1;

    dffre #(.W(3)) u_phase (
        .clk(clk), .rst_n(reset), .en(1'b1),
        .d(ph_d), .q(ph_raw)
    );
    assign ph_q = phase_e'(ph_raw);

    always_comb begin
        ph_d = ph_q;
        if (evt_on) begin
            ph_d = PH_ATTACK;
        end else if (evt_off) begin
            ph_d = (gain_q == 4'd0) ? PH_IDLE : PH_RELEASE;
        end else if (bnd) begin
            unique case (ph_q)
                PH_ATTACK: if (gain_inc == MAX_GAIN_IDX)
                    ph_d = (sus_q == MAX_GAIN_IDX) ? PH_SUSTAIN
                                                   : PH_DECAY;
                PH_DECAY: if (gain_dec <= sus_q)
                    ph_d = PH_SUSTAIN;
                PH_RELEASE: if (gain_dec == 4'd0)
                    ph_d = PH_IDLE;
                default: ph_d = ph_q;
            endcase
        end
    end

    always_comb begin
        gain_d = gain_q;
        step_d = 1'b0;
        if (!evt_on && !evt_off && bnd) begin
            unique case (ph_q)
                PH_ATTACK:           gain_d = gain_inc;
                PH_DECAY, PH_RELEASE: gain_d = gain_dec;
                default:             gain_d = gain_q;
            endcase
            step_d = (gain_d != gain_q);
        end
        done_d = (ph_d == PH_IDLE) && (ph_q != PH_IDLE);
    end

    dffre #(.W(4)) u_gain (
        .clk(clk), .rst_n(reset), .en(1'b1),
        .d(gain_d), .q(gain_q)
    );

    dffre #(.W(2)) u_pulse (
        .clk(clk), .rst_n(reset), .en(1'b1),
        .d({step_d, done_d}), .q({step_q, done_q})
    );

    assign phase     = ph_raw;
    assign gain_idx  = gain_q;
    assign step_tick = step_q;
    assign done      = done_q;
    assign busy      = (ph_q != PH_IDLE);

endmodule

// File: tb/tb_env_sequencer.sv
// Scoreboard bench for env_sequencer: directed stimulus queues expected
// output events; a negedge monitor pops and compares them.
module tb_env_sequencer;
    import adsr_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sample_tick = 1'b0;
    logic        note_on = 1'b0;
    logic        note_off = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [15:0] cfg_data = 16'd0;
    logic [2:0]  phase;
    logic [3:0]  gain_idx;
    logic        step_tick, busy, done;

    typedef struct packed {
        logic [2:0] ph;
        logic [3:0] g;
        logic       st;
        logic       dn;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    logic [2:0] prev_ph = 3'd0;

    always #5 clk = ~clk;

    env_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .note_on     (note_on),
        .note_off    (note_off),
        .cfg_wr      (cfg_wr),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .phase       (phase),
        .gain_idx    (gain_idx),
        .step_tick   (step_tick),
        .busy        (busy),
        .done        (done)
    );

    // An output event is any pulse or phase change.
    always @(negedge clk) begin
        if (mon_en && (step_tick || done || phase != prev_ph)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got ph=%0d g=%0d st=%0b dn=%0b, required no event",
                         phase, gain_idx, step_tick, done);
            end else begin
                mon_e = sb.pop_front();
                if ({phase, gain_idx, step_tick, done} !== mon_e ||
                    busy !== (mon_e.ph != 3'd0)) begin
                    errors++;
                    $display("FAIL out_event: got ph=%0d g=%0d st=%0b dn=%0b busy=%0b, required ph=%0d g=%0d st=%0b dn=%0b",
                             phase, gain_idx, step_tick, done, busy,
                             mon_e.ph, mon_e.g, mon_e.st, mon_e.dn);
                end
            end
        end
        prev_ph = phase;
    end

    task automatic expect_out(input logic [2:0] ph, input logic [3:0] g,
                              input logic st, input logic dn);
        exp_t e;
        e.ph = ph;
        e.g  = g;
        e.st = st;
        e.dn = dn;
        sb.push_back(e);
    endtask

    task automatic drive(input logic t, input logic on, input logic off);
        sample_tick = t;
        note_on     = on;
        note_off    = off;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        note_on     = 1'b0;
        note_off    = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] a, input logic [15:0] d);
        cfg_wr   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_wr = 1'b0;
    endtask

    // n ticks; the boundary event is expected only on the last one.
    task automatic bnd(input int n, input logic [2:0] ph,
                       input logic [3:0] g, input logic dn);
        repeat (n - 1) drive(1'b1, 1'b0, 1'b0);
        expect_out(ph, g, 1'b1, dn);
        drive(1'b1, 1'b0, 1'b0);
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("reset_state", {25'd0, phase, gain_idx},
            {25'd0, 3'd0, 4'd0});
        chk("reset_pulses", {29'd0, step_tick, busy, done}, 32'd0);
        mon_en = 1'b1;

        cfg(CFG_ATTACK, 16'd2);
        cfg(CFG_DECAY, 16'd2);
        cfg(CFG_RELEASE, 16'd2);
        cfg(CFG_SUSTAIN, 16'd6);
        drive(1'b0, 1'b0, 1'b1);

        // Full envelope, lens 2/2/2, sustain 6
        expect_out(3'd1, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        for (int g = 1; g <= 8; g++) bnd(2, 3'd1, 4'(g), 1'b0);
        bnd(2, 3'd2, 4'd9, 1'b0);
        bnd(2, 3'd2, 4'd8, 1'b0);
        bnd(2, 3'd2, 4'd7, 1'b0);
        bnd(2, 3'd3, 4'd6, 1'b0);
        repeat (3) drive(1'b1, 1'b0, 1'b0);
        cfg(CFG_ATTACK, 16'd2);
        expect_out(3'd4, 4'd6, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        for (int g = 5; g >= 1; g--) bnd(2, 3'd4, 4'(g), 1'b0);
        bnd(2, 3'd0, 4'd0, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 1'b0);

        // Sustain 12 clamps to 9: attack goes straight to sustain
        cfg(CFG_SUSTAIN, 16'd12);
        expect_out(3'd1, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        for (int g = 1; g <= 8; g++) bnd(2, 3'd1, 4'(g), 1'b0);
        bnd(2, 3'd3, 4'd9, 1'b0);
        repeat (2) drive(1'b1, 1'b0, 1'b0);
        expect_out(3'd4, 4'd9, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        for (int g = 8; g >= 1; g--) bnd(2, 3'd4, 4'(g), 1'b0);
        bnd(2, 3'd0, 4'd0, 1'b1);
        cfg(CFG_SUSTAIN, 16'd6);

        // note_off at attack gain 4, then at gain 0
        expect_out(3'd1, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        for (int g = 1; g <= 4; g++) bnd(2, 3'd1, 4'(g), 1'b0);
        expect_out(3'd4, 4'd4, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        for (int g = 3; g >= 1; g--) bnd(2, 3'd4, 4'(g), 1'b0);
        bnd(2, 3'd0, 4'd0, 1'b1);
        expect_out(3'd1, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        expect_out(3'd0, 4'd0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        repeat (2) drive(1'b0, 1'b0, 1'b0);

        // Retrigger in release at gain 3; on+off together in sustain
        expect_out(3'd1, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        for (int g = 1; g <= 8; g++) bnd(2, 3'd1, 4'(g), 1'b0);
        bnd(2, 3'd2, 4'd9, 1'b0);
        bnd(2, 3'd2, 4'd8, 1'b0);
        bnd(2, 3'd2, 4'd7, 1'b0);
        bnd(2, 3'd3, 4'd6, 1'b0);
        expect_out(3'd4, 4'd6, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        for (int g = 5; g >= 3; g--) bnd(2, 3'd4, 4'(g), 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        expect_out(3'd1, 4'd3, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        bnd(1, 3'd1, 4'd4, 1'b0);
        for (int g = 5; g <= 8; g++) bnd(2, 3'd1, 4'(g), 1'b0);
        bnd(2, 3'd2, 4'd9, 1'b0);
        bnd(2, 3'd2, 4'd8, 1'b0);
        bnd(2, 3'd2, 4'd7, 1'b0);
        bnd(2, 3'd3, 4'd6, 1'b0);
        expect_out(3'd1, 4'd6, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        expect_out(3'd4, 4'd6, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        for (int g = 5; g >= 1; g--) bnd(2, 3'd4, 4'(g), 1'b0);
        bnd(2, 3'd0, 4'd0, 1'b1);

        // Event swallows a coincident boundary tick; reset mid-decay
        expect_out(3'd1, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        bnd(1, 3'd1, 4'd1, 1'b0);
        for (int g = 2; g <= 8; g++) bnd(2, 3'd1, 4'(g), 1'b0);
        bnd(2, 3'd2, 4'd9, 1'b0);
        bnd(2, 3'd2, 4'd8, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        expect_out(3'd0, 4'd0, 1'b0, 1'b0);
        reset       = 1'b0;
        note_on     = 1'b1;
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        reset       = 1'b1;
        note_on     = 1'b0;
        sample_tick = 1'b0;
        chk("mid_reset", {25'd0, phase, gain_idx}, 32'd0);
        chk("mid_reset_pulses", {29'd0, step_tick, busy, done}, 32'd0);

        // Lengths back at their 480-tick default after reset
        expect_out(3'd1, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        bnd(480, 3'd1, 4'd1, 1'b0);
        cfg(CFG_RELEASE, 16'd2);
        expect_out(3'd4, 4'd1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        bnd(2, 3'd0, 4'd0, 1'b1);

        // Zero length steps every tick; length changes mid-phase
        cfg(CFG_ATTACK, 16'd0);
        expect_out(3'd1, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        bnd(1, 3'd1, 4'd1, 1'b0);
        bnd(1, 3'd1, 4'd2, 1'b0);
        cfg(CFG_ATTACK, 16'd3);
        bnd(3, 3'd1, 4'd3, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        cfg(CFG_ATTACK, 16'd2);
        bnd(1, 3'd1, 4'd4, 1'b0);
        expect_out(3'd4, 4'd4, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        for (int g = 3; g >= 1; g--) bnd(2, 3'd4, 4'(g), 1'b0);
        bnd(2, 3'd0, 4'd0, 1'b1);
        repeat (3) drive(1'b0, 1'b0, 1'b0);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
